uart_tx_scheduler: RTL

- Shares one UART transmitter between NUM_REQ byte-producing requesters, using round-robin arbitration.
- Latches the granted byte and pulses the transmitter's start input. It then waits for the transmitter's done pulse before serving the next request.
- Optionally sends a one-byte requester-ID header before each payload byte. A watchdog recovers from a lost done pulse.
- Sits between the client logic and the UART transmitter inside the UART top level.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rr_arbiter.sv | 40 ++++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_pkg;

  // Scheduler sequencing: arbitrate, then one start/wait pair per byte sent.
  typedef enum logic [2:0] {
    IDLE,
    START_HDR,
    WAIT_HDR,
    START_DAT,
    WAIT_DAT
  } sched_state_t;

  // Fill value for the unused upper bits of the requester-ID header byte.
  localparam logic HDR_PAD_ZERO = 1'b0;

  // Bit width needed to index n items, never below 1 so single-entry builds still elaborate.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick starting at a rotating pointer
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk upward from rr_ptr with wrap-around; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    sum       = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter among round-robin requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int ADD_HEADER     = 1,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int ID_W           = clog2_safe(NUM_REQ),
  localparam int WD_W           = clog2_safe(TIMEOUT_CYCLES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data_in,
  output logic                          start,
  input  logic                          tx_active,
  input  logic                          done_tx,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err
);

  sched_state_t            state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         ptr_next;
  logic [WD_W-1:0]         wd_cnt;
  logic                    wd_last;
  logic [DATA_WIDTH-1:0]   payload;
  logic [DATA_WIDTH-1:0]   hdr_byte;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [ID_W-1:0]         arb_idx;
  logic                    arb_any;
  logic                    arb_en;

  // A busy transmitter blocks arbitration entirely, so no byte is accepted early.
  assign arb_en  = (state == IDLE) && !tx_active;
  assign wd_last = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign busy    = (state != IDLE);

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Pointer moves just past the winner so a requester holding valid waits for everyone else.
  always_comb begin
    ptr_next = '0;
    if (arb_idx != ID_W'(NUM_REQ - 1)) ptr_next = arb_idx + ID_W'(1);
  end

  // Header byte is the served requester index, zero-padded to the byte width.
  always_comb begin
    hdr_byte             = {DATA_WIDTH{HDR_PAD_ZERO}};
    hdr_byte[ID_W-1:0]   = grant_id;
  end

  // Scheduler FSM: arbitrate, pulse start per byte, wait for done with a watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      payload     <= '0;
      req_ready   <= '0;
      tx_data_in  <= '0;
      start       <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ready   <= '0;
      start       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && arb_any) begin
            grant_id  <= arb_idx;
            payload   <= req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            req_ready <= arb_grant;
            rr_ptr    <= ptr_next;
            if (ADD_HEADER != 0) state <= START_HDR;
            else                 state <= START_DAT;
          end
        end
        START_HDR: begin
          start      <= 1'b1;
          tx_data_in <= hdr_byte;
          wd_cnt     <= '0;
          state      <= WAIT_HDR;
        end
        START_DAT: begin
          start      <= 1'b1;
          tx_data_in <= payload;
          wd_cnt     <= '0;
          state      <= WAIT_DAT;
        end
        WAIT_HDR: begin
          if (done_tx) begin
            state <= START_DAT;
          end else if (wd_last) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        WAIT_DAT: begin
          if (done_tx) begin
            state <= IDLE;
          end else if (wd_last) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
